mandel_pixel_engine: RTL

Downstream consumer of the raster X/Y coordinate generator. Takes one 10-bit pixel coordinate per handshake and maps it to a complex point c on a configurable plane window. Iterates z <- z^2 + c in signed fixed point until the point escapes or the iteration cap is reached. Emits the iteration count with the pixel coordinate to the colour/framebuffer stage over a valid/ready handshake.

---
 rtl/mandel_pixel_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mandel_pixel_engine.sv
// mandel_pixel_engine: maps one pixel coordinate to a point c on a
// configurable complex-plane window. It then iterates z <- z^2 + c in signed
// fixed point, Q(W-FRAC).FRAC, until the point escapes or the iteration cap
// is reached, and reports the iteration count with the pixel coordinate.
//
// Handshake (both ports): a transfer happens on a rising aclk edge where
// valid && ready are both 1. A producer holds valid and its payload stable
// until that edge. in_ready depends only on state and aresetn, never on
// in_valid. Once out_valid rises, it and out_* stay unchanged until
// out_ready is seen.
module mandel_pixel_engine #(
    parameter int W        = 32,
    parameter int FRAC     = 28,
    parameter int IW       = 8,
    parameter int MAX_ITER = 255
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [9:0]    in_x,
    input  logic [9:0]    in_y,
    input  logic [W-1:0]  re_min,
    input  logic [W-1:0]  im_max,
    input  logic [W-1:0]  step,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [9:0]    out_x,
    output logic [9:0]    out_y,
    output logic [IW-1:0] out_iter,
    output logic          out_inside
);

    typedef enum logic [1:0] {IDLE, MAP, ITER, DONE} state_t;

    // Current FSM state. Checkers can probe this signal by hierarchical name.
    state_t state;
    state_t state_next;

    localparam logic signed [W+1:0] FOUR = (W+2)'(4) <<< FRAC;

    logic [9:0]          x_q, y_q;
    logic [W-1:0]        re_min_q, im_max_q, step_q;
    logic [W-1:0]        x_off, y_off;
    logic signed [W-1:0] c_re, c_im, zr, zi, zr_new, zi_new;
    logic [IW-1:0]       iter, iter_inc;

    logic signed [2*W-1:0] zr_ext, zi_ext, p_rr, p_ii, p_ri;
    logic signed [W+1:0]   zr2, zi2, mag2;
    logic [W+1:0]          diff;
    logic                  escape, cap_hit, accept;
    logic                  unused_product_bits;

    // Fixed-point datapath for one iteration step and for mapping a pixel
    // onto the plane.
    always_comb begin
        zr_ext   = {{W{zr[W-1]}}, zr};
        zi_ext   = {{W{zi[W-1]}}, zi};
        p_rr     = zr_ext * zr_ext;
        p_ii     = zi_ext * zi_ext;
        p_ri     = zr_ext * zi_ext;
        // Realigning to FRAC is an arithmetic shift. Keeping W+2 bits stops
        // the magnitude sum from overflowing for |z| <= 2.
        zr2      = p_rr[FRAC+W+1:FRAC];
        zi2      = p_ii[FRAC+W+1:FRAC];
        mag2     = zr2 + zi2;
        escape   = mag2 > FOUR;
        diff     = zr2 - zi2;
        zr_new   = diff[W-1:0] + c_re;
        // 2*zr*zi comes from shifting by one bit less than FRAC.
        zi_new   = p_ri[FRAC+W-2:FRAC-1] + c_im;
        iter_inc = iter + 1'b1;
        cap_hit  = (iter_inc == IW'(MAX_ITER));
        // Pixel offsets: zero-extended coordinate times step. The result
        // wraps to W bits.
        x_off    = {{(W-10){1'b0}}, x_q} * step_q;
        y_off    = {{(W-10){1'b0}}, y_q} * step_q;
    end

    // Product bits that the fixed-point alignment throws away.
    assign unused_product_bits = ^{p_rr[2*W-1:FRAC+W+2], p_rr[FRAC-1:0],
                                   p_ii[2*W-1:FRAC+W+2], p_ii[FRAC-1:0],
                                   p_ri[2*W-1:FRAC+W-1], p_ri[FRAC-2:0],
                                   diff[W+1:W]};

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and input-side ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = aresetn;
                if (in_valid && aresetn) state_next = MAP;
            end
            MAP:     state_next = ITER;
            ITER:    if (escape || cap_hit) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Latches the pixel, runs one iteration per cycle in ITER, and registers
    // the result.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            x_q        <= '0;
            y_q        <= '0;
            re_min_q   <= '0;
            im_max_q   <= '0;
            step_q     <= '0;
            c_re       <= '0;
            c_im       <= '0;
            zr         <= '0;
            zi         <= '0;
            iter       <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_iter   <= '0;
            out_inside <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q      <= in_x;
                        y_q      <= in_y;
                        re_min_q <= re_min;
                        im_max_q <= im_max;
                        step_q   <= step;
                    end
                end
                MAP: begin
                    c_re <= re_min_q + x_off;
                    c_im <= im_max_q - y_off;
                    zr   <= '0;
                    zi   <= '0;
                    iter <= '0;
                end
                ITER: begin
                    if (escape) begin
                        out_iter   <= iter;
                        out_inside <= 1'b0;
                        out_x      <= x_q;
                        out_y      <= y_q;
                        out_valid  <= 1'b1;
                    end else begin
                        zr   <= zr_new;
                        zi   <= zi_new;
                        iter <= iter_inc;
                        if (cap_hit) begin
                            out_iter   <= IW'(MAX_ITER);
                            out_inside <= 1'b1;
                            out_x      <= x_q;
                            out_y      <= y_q;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
